nvcm_pgm_ctrl: RTL and testbench
================================

// Module: nvcm_pgm_ctrl
// PURPOSE
//  Word-level program/verify and read sequencer that drives the NVCM array's fsm_* pins and samples nv_dataout.
//  Accepts one 9-bit word request (read or program) for the bstream, redrow, rritrim or sisiui bank.
//  Programs bit by bit with timed HV pulses, then reads back. Retries only the failing bits, up to MAX_RETRY times.
//  Sits between the configuration/boot master and the NVCM array.
// PARAMETERS
//  COL_W       8  column address width (fsm_coladd)
//  ROW_W       9  row address width (fsm_rowadd)
//  BLK_W       4  bit-in-word select width (fsm_blkadd, values 0..8)
//  PGM_PULSE   4  cycles fsm_pgmhv is held high per bit, >=1
//  SAMPLE_DLY  2  cycles fsm_rd is high before the fsm_sample pulse, >=1
//  MAX_RETRY   2  reprogram passes after the first verify fails, >=0
// PORTS
//  clk             in   1      clock
//  rst_b           in   1      reset, synchronous, active-low
//  req_valid       in   1      request valid
//  req_ready       out  1      high only in IDLE; a request is accepted when req_valid && req_ready
//  req_op          in   1      0 = read, 1 = program+verify
//  req_target      in   2      0 = bstream, 1 = redrow, 2 = rritrim, 3 = sisiui
//  req_row         in   ROW_W  row address
//  req_col         in   COL_W  column address
//  req_data        in   9      word to program
//  rsp_valid       out  1      one-cycle pulse, response valid
//  rsp_data        out  9      word read back
//  rsp_err         out  1      verify still failing after MAX_RETRY retries
//  busy            out  1      high when state != IDLE
//  fsm_nv_bstream / fsm_nv_redrow / fsm_nv_rri_trim / fsm_nv_sisi_ui  out 1 each  one-hot bank select
//  fsm_rowadd      out  ROW_W  row address to array
//  fsm_coladd      out  COL_W  column address to array
//  fsm_blkadd      out  BLK_W  bit select to array
//  fsm_pgm         out  1      program mode
//  fsm_pgmhv       out  1      high-voltage pulse
//  fsm_din         out  1      bit value to program
//  fsm_rd          out  1      read mode
//  fsm_sample      out  1      read-sample strobe (array latches on its rising edge)
//  nv_dataout      in   9      array read data
// BEHAVIOUR
//  Reset: every output is 0 except req_ready=1. State returns to IDLE; the request and retry registers clear.
//   Reset mid-operation aborts with no response; outputs reach reset values at that clock edge.
//  Registered outputs. Bank select, row and col are latched at accept and held stable until DONE, then cleared to 0.
//  States and transitions:
//   IDLE     -> on accept: PGM_SEL if req_op=1, else RD_SETUP. On a program accept, mask is set to 9'h1FF.
//   PGM_SEL  -> bit = lowest set bit of mask (0 cycles, combinational). If mask==0 go to RD_SETUP, else SETUP.
//   SETUP    -> 1 cycle: fsm_pgm=1, fsm_blkadd=bit, fsm_din=req_data[bit].
//   HV       -> PGM_PULSE cycles: fsm_pgm=1, fsm_pgmhv=1. blkadd and din are unchanged.
//   HOLD     -> 1 cycle: fsm_pgm=1, fsm_pgmhv=0. Clear mask[bit], then go to PGM_SEL.
//   RD_SETUP -> 1 cycle: fsm_rd=1.
//   RD_WAIT  -> SAMPLE_DLY cycles: fsm_rd=1.
//   SAMPLE   -> 1 cycle: fsm_rd=1, fsm_sample=1.
//   CAPTURE  -> 1 cycle: fsm_rd=1, fsm_sample=0. Covers the array output delay.
//   CHECK    -> 1 cycle: register nv_dataout.
//               Read: go to DONE, err=0.
//               Program: diff = nv_dataout ^ req_data.
//                 diff==0: DONE, err=0.
//                 retry<MAX_RETRY: mask=diff, retry+1, go to PGM_SEL.
//                 Otherwise: DONE, err=1.
//   DONE     -> 1 cycle: rsp_valid=1, rsp_data = captured word. Next state IDLE.
//  fsm_pgm and fsm_rd are never high in the same cycle. fsm_pgmhv is only high while fsm_pgm is high.
//  Latency from the accept edge to the rsp_valid cycle:
//   read = SAMPLE_DLY+5
//   full-word program, first pass clean = 9*(PGM_PULSE+2)+SAMPLE_DLY+5
//   each retry adds popcount(diff)*(PGM_PULSE+2)+SAMPLE_DLY+4
//  req_valid while busy is ignored (not queued). The retry counter is ceil(log2(MAX_RETRY+1)) bits wide and saturates.
// STRUCTURE
//  Shared package nvcm_pkg: bank-target encoding, state enum, word width (9).
//  Sub-module nvcm_bit_sel: 9-bit lowest-set-bit priority encoder giving BLK_W index plus a none flag.
// TESTING (PGM_PULSE=4, SAMPLE_DLY=2, MAX_RETRY=2, against the NVCM array model)
//  1. Program 9'h1A5 to bstream row 3, col 7.
//     -> 9 HV pulses of 4 cycles each, blkadd 0..8 in order.
//     -> rsp_valid 61 cycles after accept, rsp_data=9'h1A5, err=0.
//  2. Read rritrim col 5 preloaded with 9'h0C3.
//     -> fsm_sample rises 4 cycles after accept; rsp_valid at cycle 7; data=9'h0C3; fsm_pgm never high.
//  3. Array forced to invert bit 2 at the target address.
//     -> two retries, each pulsing only blkadd=2.
//     -> rsp_err=1, rsp_data=req_data^9'h004, 24 extra cycles in total.
//  4. Redrow program, row 9'h01B, col 0.
//     -> only fsm_nv_redrow is high, rowadd=9'h01B held for the whole operation.
//     -> later read returns the same word.
//  5. rst_b low for 1 cycle during HV of bit 4.
//     -> next cycle all fsm_* are 0 and req_ready=1, no rsp_valid.
//     -> a new read is accepted immediately.
//  6. req_valid held high through DONE.
//     -> second request accepted the cycle after DONE (IDLE); no back-to-back overlap of fsm_pgm and fsm_rd.

Source files
------------

// File: rtl/nvcm_pkg.sv
// Shared definitions for the NVCM program/verify sequencer: word width,
// bank-target encoding, sequencer state encoding and a bank one-hot helper.
package nvcm_pkg;

  localparam int unsigned WORD_W = 9;

  typedef enum logic [1:0] {
    TGT_BSTREAM = 2'd0,
    TGT_REDROW  = 2'd1,
    TGT_RRITRIM = 2'd2,
    TGT_SISIUI  = 2'd3
  } nvcm_target_e;

  // Bit selection between program pulses is combinational, so it has no state.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HV,
    ST_HOLD,
    ST_RD_SETUP,
    ST_RD_WAIT,
    ST_SAMPLE,
    ST_CAPTURE,
    ST_CHECK,
    ST_DONE
  } nvcm_state_e;

  // Bank select one-hot: bit 0 bstream, 1 redrow, 2 rritrim, 3 sisiui.
  function automatic logic [3:0] bank_onehot(input logic [1:0] tgt);
    return 4'b0001 << tgt;
  endfunction

endpackage

// File: rtl/nvcm_bit_sel.sv
// Lowest-set-bit priority encoder over a 9-bit mask.
//   mask : bits still to be programmed
//   idx  : index of the lowest set bit (0 when mask is empty)
//   none : mask is all zero
module nvcm_bit_sel
  import nvcm_pkg::*;
#(
  parameter int unsigned BLK_W = 4
) (
  input  logic [WORD_W-1:0] mask,
  output logic [BLK_W-1:0]  idx,
  output logic              none
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int unsigned i = WORD_W; i > 0; i--) begin
      if (mask[i-1]) begin
        idx  = BLK_W'(i - 1);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/nvcm_pgm_ctrl.sv
// Word-level program/verify and read sequencer for the NVCM array.
// Accepts one 9-bit read or program request, programs each bit with a timed
// HV pulse, reads the word back, and reprograms only the failing bits up to
// MAX_RETRY times.
//   req_*   : request handshake (accepted when req_valid && req_ready)
//   rsp_*   : one-cycle response pulse with read-back word and error flag
//   busy    : sequencer not idle
//   fsm_*   : registered array controls (bank select, address, pgm/rd strobes)
//   nv_dataout : array read data, captured in the check cycle
module nvcm_pgm_ctrl
  import nvcm_pkg::*;
#(
  parameter int unsigned COL_W      = 8,
  parameter int unsigned ROW_W      = 9,
  parameter int unsigned BLK_W      = 4,
  parameter int unsigned PGM_PULSE  = 4,
  parameter int unsigned SAMPLE_DLY = 2,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [1:0]       req_target,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  input  logic [8:0]       req_data,
  output logic             rsp_valid,
  output logic [8:0]       rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic             fsm_nv_bstream,
  output logic             fsm_nv_redrow,
  output logic             fsm_nv_rri_trim,
  output logic             fsm_nv_sisi_ui,
  output logic [ROW_W-1:0] fsm_rowadd,
  output logic [COL_W-1:0] fsm_coladd,
  output logic [BLK_W-1:0] fsm_blkadd,
  output logic             fsm_pgm,
  output logic             fsm_pgmhv,
  output logic             fsm_din,
  output logic             fsm_rd,
  output logic             fsm_sample,
  input  logic [8:0]       nv_dataout
);

  localparam int unsigned MAX_DLY = (PGM_PULSE > SAMPLE_DLY) ? PGM_PULSE : SAMPLE_DLY;
  localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1);
  localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  nvcm_state_e       state_q, state_d;
  logic [WORD_W-1:0] mask_q, mask_d, data_q, data_d;
  logic              op_q, op_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BLK_W-1:0]  bit_q, bit_d;
  logic [3:0]        bank_q, bank_d;
  logic [ROW_W-1:0]  row_d;
  logic [COL_W-1:0]  col_d;

  logic              req_ready_d, busy_d, rsp_valid_d, rsp_err_d;
  logic [8:0]        rsp_data_d;
  logic [BLK_W-1:0]  blkadd_d;
  logic              pgm_d, pgmhv_d, din_d, rd_d, sample_d;

  logic [WORD_W-1:0] diff, sel_mask;
  logic [BLK_W-1:0]  sel_idx;
  logic              sel_none;

  assign fsm_nv_bstream  = bank_q[0];
  assign fsm_nv_redrow   = bank_q[1];
  assign fsm_nv_rri_trim = bank_q[2];
  assign fsm_nv_sisi_ui  = bank_q[3];

  // One encoder serves all three bit-selection points: fresh program (all
  // ones), after a bit completes (mask minus that bit) and on retry (diff).
  always_comb begin
    diff     = nv_dataout ^ data_q;
    sel_mask = '1;
    case (state_q)
      ST_HOLD:  sel_mask = mask_q & ~(WORD_W'(1) << bit_q);
      ST_CHECK: sel_mask = diff;
      default:  ;
    endcase
  end

  nvcm_bit_sel #(.BLK_W(BLK_W)) u_bit_sel (
    .mask (sel_mask),
    .idx  (sel_idx),
    .none (sel_none)
  );

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    data_d      = data_q;
    op_d        = op_q;
    retry_d     = retry_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    bank_d      = bank_q;
    row_d       = fsm_rowadd;
    col_d       = fsm_coladd;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          bank_d  = bank_onehot(req_target);
          row_d   = req_row;
          col_d   = req_col;
          data_d  = req_data;
          op_d    = req_op;
          retry_d = '0;
          if (req_op) begin
            mask_d  = '1;
            bit_d   = sel_idx;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_RD_SETUP;
          end
        end
      end
      ST_SETUP: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_HV;
      end
      ST_HV: begin
        if (cnt_q == CNT_W'(PGM_PULSE)) state_d = ST_HOLD;
        else                            cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_HOLD: begin
        mask_d = sel_mask;
        if (sel_none) begin
          state_d = ST_RD_SETUP;
        end else begin
          bit_d   = sel_idx;
          state_d = ST_SETUP;
        end
      end
      ST_RD_SETUP: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (cnt_q == CNT_W'(SAMPLE_DLY)) state_d = ST_SAMPLE;
        else                             cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_SAMPLE:  state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (!op_q || diff == '0) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = nv_dataout;
        end else if (32'(retry_q) < MAX_RETRY) begin
          mask_d  = diff;
          retry_d = retry_q + RTY_W'(1);
          bit_d   = sel_idx;
          state_d = ST_SETUP;
        end else begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = nv_dataout;
          rsp_err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        mask_d  = '0;
        bank_d  = '0;
        row_d   = '0;
        col_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    pgm_d       = state_d inside {ST_SETUP, ST_HV, ST_HOLD};
    pgmhv_d     = (state_d == ST_HV);
    rd_d        = state_d inside {ST_RD_SETUP, ST_RD_WAIT, ST_SAMPLE, ST_CAPTURE};
    sample_d    = (state_d == ST_SAMPLE);
    blkadd_d    = pgm_d ? bit_d : '0;
    din_d       = pgm_d ? data_d[bit_d] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      data_q     <= '0;
      op_q       <= 1'b0;
      retry_q    <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      bank_q     <= '0;
      fsm_rowadd <= '0;
      fsm_coladd <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      fsm_blkadd <= '0;
      fsm_pgm    <= 1'b0;
      fsm_pgmhv  <= 1'b0;
      fsm_din    <= 1'b0;
      fsm_rd     <= 1'b0;
      fsm_sample <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      op_q       <= op_d;
      retry_q    <= retry_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      bank_q     <= bank_d;
      fsm_rowadd <= row_d;
      fsm_coladd <= col_d;
      req_ready  <= req_ready_d;
      busy       <= busy_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      rsp_err    <= rsp_err_d;
      fsm_blkadd <= blkadd_d;
      fsm_pgm    <= pgm_d;
      fsm_pgmhv  <= pgmhv_d;
      fsm_din    <= din_d;
      fsm_rd     <= rd_d;
      fsm_sample <= sample_d;
    end
  end

endmodule

// File: tb/tb_nvcm_pgm_ctrl.sv
// Self-checking bench for nvcm_pgm_ctrl with a behavioural NVCM array model.
// A transaction-level model expands each request into the per-cycle output
// trace implied by the sequencing rules; a compare process checks every cycle.
module tb_nvcm_pgm_ctrl;

  localparam int unsigned COL_W      = 8;
  localparam int unsigned ROW_W      = 9;
  localparam int unsigned BLK_W      = 4;
  localparam int unsigned PGM_PULSE  = 4;
  localparam int unsigned SAMPLE_DLY = 2;
  localparam int unsigned MAX_RETRY  = 2;

  logic             clk, rst_b;
  logic             req_valid, req_ready, req_op;
  logic [1:0]       req_target;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic [8:0]       req_data;
  logic             rsp_valid, rsp_err, busy;
  logic [8:0]       rsp_data;
  logic             fsm_nv_bstream, fsm_nv_redrow, fsm_nv_rri_trim, fsm_nv_sisi_ui;
  logic [ROW_W-1:0] fsm_rowadd;
  logic [COL_W-1:0] fsm_coladd;
  logic [BLK_W-1:0] fsm_blkadd;
  logic             fsm_pgm, fsm_pgmhv, fsm_din, fsm_rd, fsm_sample;
  logic [8:0]       nv_dataout;

  nvcm_pgm_ctrl #(
    .COL_W(COL_W), .ROW_W(ROW_W), .BLK_W(BLK_W),
    .PGM_PULSE(PGM_PULSE), .SAMPLE_DLY(SAMPLE_DLY), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_target(req_target), .req_row(req_row), .req_col(req_col), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .fsm_nv_bstream(fsm_nv_bstream), .fsm_nv_redrow(fsm_nv_redrow),
    .fsm_nv_rri_trim(fsm_nv_rri_trim), .fsm_nv_sisi_ui(fsm_nv_sisi_ui),
    .fsm_rowadd(fsm_rowadd), .fsm_coladd(fsm_coladd), .fsm_blkadd(fsm_blkadd),
    .fsm_pgm(fsm_pgm), .fsm_pgmhv(fsm_pgmhv), .fsm_din(fsm_din),
    .fsm_rd(fsm_rd), .fsm_sample(fsm_sample), .nv_dataout(nv_dataout)
  );

  typedef struct packed {
    logic       rdy, bsy, rv;
    logic [8:0] rdat;
    logic       rerr;
    logic [3:0] bank;
    logic [8:0] row;
    logic [7:0] col;
    logic [3:0] blk;
    logic       pgm, hv, din, rd, smp;
  } ov_t;

  int   tests = 0, fails = 0;
  int   cyc = 0, acc_edge = 0;
  bit   cmp_en = 0;
  ov_t  q[$];
  ov_t  dut_v;

  logic [8:0] arr [int];   // array contents as programmed through the pins
  logic [8:0] sh  [int];   // model's own view of the contents
  int         fault_key = -1;
  logic [8:0] fault_mask = '0;

  // stats gathered from the pins
  logic [3:0] hv_blk[$];
  int   hv_cycles, pgm_cycles, overlap = 0, samp_lat, busy_rise, done_cyc, rsp_cnt = 0;
  int   last_lat, hold_bad;
  logic [8:0] last_data;
  logic last_err, hv_prev = 0, samp_prev = 0, busy_prev = 0, hold_en = 0;
  logic [3:0] hold_bank;
  logic [8:0] hold_row;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial begin #500000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1, "timeout"); end

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    dut_v      = '0;
    dut_v.rdy  = req_ready;  dut_v.bsy = busy;  dut_v.rv = rsp_valid;
    dut_v.rdat = rsp_data;   dut_v.rerr = rsp_err;
    dut_v.bank = {fsm_nv_sisi_ui, fsm_nv_rri_trim, fsm_nv_redrow, fsm_nv_bstream};
    dut_v.row  = fsm_rowadd; dut_v.col = fsm_coladd; dut_v.blk = fsm_blkadd;
    dut_v.pgm  = fsm_pgm;    dut_v.hv = fsm_pgmhv;   dut_v.din = fsm_din;
    dut_v.rd   = fsm_rd;     dut_v.smp = fsm_sample;
  end

  function automatic int key_of(input logic [1:0] t, input logic [8:0] r, input logic [7:0] c);
    return int'({t, r, c});
  endfunction

  function automatic logic [1:0] tgt_of(input logic [3:0] b);
    return b[1] ? 2'd1 : b[2] ? 2'd2 : b[3] ? 2'd3 : 2'd0;
  endfunction

  // NVCM array: each HV cycle writes din into the selected bit; the word is
  // latched on the rising edge of fsm_sample (with an optional stuck fault).
  always @(posedge clk) begin
    int k; logic [8:0] w;
    if (fsm_pgm && fsm_pgmhv) begin
      k = key_of(tgt_of(dut_v.bank), fsm_rowadd, fsm_coladd);
      w = arr.exists(k) ? arr[k] : '0;
      w[fsm_blkadd] = fsm_din;
      arr[k] = w;
    end
  end

  initial nv_dataout = '0;
  always @(posedge fsm_sample) begin
    int k; logic [8:0] w;
    k = key_of(tgt_of(dut_v.bank), fsm_rowadd, fsm_coladd);
    w = arr.exists(k) ? arr[k] : '0;
    if (k == fault_key) w = w ^ fault_mask;
    nv_dataout <= w;
  end

  function automatic ov_t idle_v();
    ov_t v = '0;
    v.rdy = 1'b1;
    return v;
  endfunction

  function automatic ov_t op_v(input logic [3:0] bk, input logic [8:0] r, input logic [7:0] c,
                               input int b, input logic pg, input logic hv, input logic dn,
                               input logic rd, input logic smp);
    ov_t v = '0;
    v.bsy = 1'b1; v.bank = bk; v.row = r; v.col = c; v.blk = 4'(b);
    v.pgm = pg; v.hv = hv; v.din = dn; v.rd = rd; v.smp = smp;
    return v;
  endfunction

  // Expand one request into its expected per-cycle trace, ending with DONE and IDLE.
  task automatic model_txn(input logic op, input logic [1:0] t, input logic [8:0] r,
                           input logic [7:0] c, input logic [8:0] d);
    logic [3:0] bk; logic [8:0] mask, rdw, diff, w; int k, retry; logic err; ov_t v;
    bk = 4'b0001 << t; k = key_of(t, r, c); err = 0; retry = 0;
    mask = op ? 9'h1FF : 9'h000;
    forever begin
      for (int b = 0; b < 9; b++) begin
        if (mask[b]) begin
          q.push_back(op_v(bk, r, c, b, 1, 0, d[b], 0, 0));
          repeat (PGM_PULSE) q.push_back(op_v(bk, r, c, b, 1, 1, d[b], 0, 0));
          q.push_back(op_v(bk, r, c, b, 1, 0, d[b], 0, 0));
          w = sh.exists(k) ? sh[k] : '0;
          w[b] = d[b];
          sh[k] = w;
        end
      end
      q.push_back(op_v(bk, r, c, 0, 0, 0, 0, 1, 0));
      repeat (SAMPLE_DLY) q.push_back(op_v(bk, r, c, 0, 0, 0, 0, 1, 0));
      q.push_back(op_v(bk, r, c, 0, 0, 0, 0, 1, 1));
      q.push_back(op_v(bk, r, c, 0, 0, 0, 0, 1, 0));
      q.push_back(op_v(bk, r, c, 0, 0, 0, 0, 0, 0));
      rdw = sh.exists(k) ? sh[k] : '0;
      if (k == fault_key) rdw = rdw ^ fault_mask;
      if (!op) break;
      diff = rdw ^ d;
      if (diff == 0) break;
      if (retry < int'(MAX_RETRY)) begin mask = diff; retry++; end
      else begin err = 1; break; end
    end
    v = op_v(bk, r, c, 0, 0, 0, 0, 0, 0);
    v.rv = 1'b1; v.rdat = rdw; v.rerr = err;
    q.push_back(v);
    q.push_back(idle_v());
  endtask

  // Per-cycle comparison against the model trace.
  always begin
    ov_t exp_v;
    @(posedge clk); #1;
    if (cmp_en) begin
      exp_v = (q.size() != 0) ? q.pop_front() : idle_v();
      tests++;
      if (dut_v !== exp_v) begin
        fails++;
        $display("FAIL cycle_cmp @%0d: dut=%h model=%h", cyc, dut_v, exp_v);
      end
    end
  end

  always begin
    @(posedge clk); #1;
    if (fsm_pgmhv && !hv_prev) hv_blk.push_back(fsm_blkadd);
    hv_prev = fsm_pgmhv;
    if (fsm_pgmhv) hv_cycles++;
    if (fsm_pgm) pgm_cycles++;
    if (fsm_pgm && fsm_rd) overlap++;
    if (fsm_sample && !samp_prev) samp_lat = cyc - acc_edge + 1;
    samp_prev = fsm_sample;
    if (busy && !busy_prev) busy_rise = cyc;
    busy_prev = busy;
    if (hold_en && busy && (dut_v.bank != hold_bank || fsm_rowadd != hold_row)) hold_bad++;
    if (rsp_valid) begin
      rsp_cnt++; last_lat = cyc - acc_edge + 1;
      last_data = rsp_data; last_err = rsp_err; done_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_stats();
    hv_blk.delete(); hv_cycles = 0; pgm_cycles = 0; samp_lat = -1; hold_bad = 0;
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after accept.
  task automatic run_txn(input logic op, input logic [1:0] t, input logic [8:0] r,
                         input logic [7:0] c, input logic [8:0] d, input bit keep);
    int n = 0;
    while (q.size() != 0) begin
      @(negedge clk); n++;
      if (n > 1000) begin tests++; fails++; $display("FAIL txn_wait: still busy after %0d cycles", n); return; end
    end
    req_op = op; req_target = t; req_row = r; req_col = c; req_data = d; req_valid = 1;
    acc_edge = cyc + 1;
    model_txn(op, t, r, c, d);
    @(negedge clk);
    if (!keep) req_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0) begin
      @(negedge clk); n++;
      if (n > 1000) begin tests++; fails++; $display("FAIL idle_wait: no completion in %0d cycles", n); return; end
    end
  endtask

  initial begin
    int rc0, da;
    rst_b = 0; req_valid = 0; req_op = 0; req_target = 0; req_row = '0; req_col = '0; req_data = '0;
    @(negedge clk); cmp_en = 1;
    @(negedge clk);
    check("reset_outputs", 32'(dut_v), 32'(idle_v()));
    check("reset_ready", req_ready, 1);
    rst_b = 1;
    @(negedge clk);

    // 1: full-word program, clean first pass
    clr_stats();
    run_txn(1, 2'd0, 9'd3, 8'd7, 9'h1A5, 0); wait_idle();
    check("t1_latency", last_lat, 61);
    check("t1_data", last_data, 9'h1A5);
    check("t1_err", last_err, 0);
    check("t1_hv_pulses", hv_blk.size(), 9);
    check("t1_hv_cycles", hv_cycles, 36);
    for (int i = 0; i < hv_blk.size() && i < 9; i++) check("t1_blk_order", hv_blk[i], i);

    // 2: read of a preloaded word
    arr[key_of(2'd2, 9'd2, 8'd5)] = 9'h0C3; sh[key_of(2'd2, 9'd2, 8'd5)] = 9'h0C3;
    clr_stats();
    run_txn(0, 2'd2, 9'd2, 8'd5, 9'h000, 0); wait_idle();
    check("t2_sample_at", samp_lat, 4);
    check("t2_latency", last_lat, 7);
    check("t2_data", last_data, 9'h0C3);
    check("t2_no_pgm", pgm_cycles, 0);

    // 3: stuck bit 2 exhausts the retries
    fault_key = key_of(2'd3, 9'h040, 8'h11); fault_mask = 9'h004;
    clr_stats();
    run_txn(1, 2'd3, 9'h040, 8'h11, 9'h0F3, 0); wait_idle();
    check("t3_latency", last_lat, 85);
    check("t3_err", last_err, 1);
    check("t3_data", last_data, 9'h0F7);
    check("t3_hv_pulses", hv_blk.size(), 11);
    if (hv_blk.size() == 11) begin
      check("t3_retry1_blk", hv_blk[9], 2);
      check("t3_retry2_blk", hv_blk[10], 2);
    end
    fault_key = -1; fault_mask = '0;

    // 4: redrow program then read back
    clr_stats(); hold_bank = 4'b0010; hold_row = 9'h01B; hold_en = 1;
    run_txn(1, 2'd1, 9'h01B, 8'd0, 9'h05A, 0); wait_idle();
    hold_en = 0;
    check("t4_bank_row_held", hold_bad, 0);
    check("t4_err", last_err, 0);
    run_txn(0, 2'd1, 9'h01B, 8'd0, 9'h000, 0); wait_idle();
    check("t4_readback", last_data, 9'h05A);

    // 5: reset during the HV pulse of bit 4
    rc0 = rsp_cnt;
    run_txn(1, 2'd0, 9'd1, 8'd1, 9'h0AA, 0);
    repeat (26) @(negedge clk);
    check("t5_in_hv", fsm_pgmhv, 1);
    check("t5_hv_bit", fsm_blkadd, 4);
    rst_b = 0; q.delete();
    @(negedge clk);
    rst_b = 1;
    check("t5_after_reset", 32'(dut_v), 32'(idle_v()));
    check("t5_ready", req_ready, 1);
    run_txn(0, 2'd2, 9'd2, 8'd5, 9'h000, 0); wait_idle();
    check("t5_read_data", last_data, 9'h0C3);
    check("t5_read_latency", last_lat, 7);
    check("t5_one_response", rsp_cnt - rc0, 1);

    // 6: req_valid held through DONE
    run_txn(1, 2'd0, 9'd5, 8'd9, 9'h155, 1);
    run_txn(0, 2'd0, 9'd5, 8'd9, 9'h000, 0);
    da = done_cyc;
    check("t6_accept_gap", busy_rise - da, 2);
    wait_idle();
    check("t6_readback", last_data, 9'h155);
    check("pgm_rd_overlap", overlap, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
